// File: rtl/victim_eviction_buffer_pkg.sv
// lc3b_types: shared line, tag and eviction-entry types plus downstream FSM states
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [11:0] lc3b_evict_tag;
  typedef struct packed {
    logic valid;
    lc3b_evict_tag tag;
    lc3b_c_line data;
  } lc3b_evict_buf_entry;
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_READ = 2'd1;
  localparam logic [1:0] D_DRAIN = 2'd2;
endpackage

// File: rtl/victim_eviction_buffer_array.sv
// evict_buf_array: eviction entry storage with parallel tag match and head/tail ports
module evict_buf_array import lc3b_types::*; #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [11:0]      lookup_tag,
  output logic             match,
  output logic [PTR_W-1:0] match_idx,
  output logic [127:0]     match_data,
  input  logic [PTR_W-1:0] head,
  output logic [11:0]      head_tag,
  output logic [127:0]     head_data,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  logic [127:0]     wr_data,
  input  logic             clr_en
);
  lc3b_evict_buf_entry ent [DEPTH];
  always_comb begin
    match = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent[i].valid && ent[i].tag == lookup_tag) begin
        match = 1'b1;
        match_idx = PTR_W'(i);
      end
  end
  assign match_data = ent[match_idx].data;
  assign head_tag = ent[head].tag;
  assign head_data = ent[head].data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (clr_en) ent[head].valid <= 1'b0;
      if (wr_en) ent[wr_idx] <= '{valid: 1'b1, tag: lookup_tag, data: wr_data};
    end
endmodule

// File: rtl/victim_eviction_buffer.sv
// victim_eviction_buffer: coalescing write-back FIFO between L1 and the victim cache
module victim_eviction_buffer import lc3b_types::*; #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         l1_mem_read,
  input  logic         l1_mem_write,
  input  logic [15:0]  l1_mem_address,
  input  logic [127:0] l1_mem_wdata,
  output logic [127:0] l1_mem_rdata,
  output logic         l1_mem_resp,
  output logic         buf_mem_read,
  output logic         buf_mem_write,
  output logic         eviction,
  output logic [15:0]  buf_mem_address,
  output logic [127:0] buf_mem_wdata,
  input  logic [127:0] buf_mem_rdata,
  input  logic         buf_mem_resp
);
  logic [1:0] state;
  logic [PTR_W:0] count;
  logic [PTR_W-1:0] head, tail, match_idx;
  logic match, rd_pending, l1_resp_q, rd_acc, wr_acc, push, pop, rd_done, unused_lo;
  lc3b_evict_tag req_tag, head_tag, tag;
  lc3b_c_line match_data, head_data;
  assign tag = l1_mem_address[15:4];
  assign unused_lo = ^l1_mem_address[3:0];
  evict_buf_array #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_array (
    .clk(clk), .reset(reset), .lookup_tag(tag), .match(match), .match_idx(match_idx),
    .match_data(match_data), .head(head), .head_tag(head_tag), .head_data(head_data),
    .wr_en(wr_acc), .wr_idx(match ? match_idx : tail), .wr_data(l1_mem_wdata), .clr_en(pop)
  );
  // the head line under drain must not change, so a write hitting it waits for the pop
  always_comb begin
    rd_acc = !l1_resp_q && !rd_pending && l1_mem_read;
    wr_acc = !l1_resp_q && !rd_pending && !l1_mem_read && l1_mem_write &&
             (match ? !(match_idx == head && state == D_DRAIN) : count != (PTR_W+1)'(DEPTH));
    push = wr_acc && !match;
    pop = state == D_DRAIN && buf_mem_resp;
    rd_done = state == D_READ && buf_mem_resp;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= D_IDLE;
      count <= '0;
      head <= '0;
      tail <= '0;
      rd_pending <= 1'b0;
      l1_resp_q <= 1'b0;
      l1_mem_rdata <= '0;
      req_tag <= '0;
    end else begin
      l1_resp_q <= (rd_acc && match) || wr_acc || rd_done;
      if (rd_acc && match) l1_mem_rdata <= match_data;
      if (rd_acc && !match) begin
        rd_pending <= 1'b1;
        req_tag <= tag;
      end
      if (rd_done) begin
        l1_mem_rdata <= buf_mem_rdata;
        rd_pending <= 1'b0;
      end
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      state <= state == D_IDLE ? (rd_pending ? D_READ : count != '0 ? D_DRAIN : D_IDLE) :
               buf_mem_resp ? D_IDLE : state;
    end
  assign l1_mem_resp = l1_resp_q;
  assign buf_mem_read = state == D_READ;
  assign eviction = state == D_DRAIN;
  assign buf_mem_write = state == D_DRAIN;
  assign buf_mem_address = state == D_READ ? {req_tag, 4'b0} : state == D_DRAIN ? {head_tag, 4'b0} : 16'h0;
  assign buf_mem_wdata = state == D_DRAIN ? head_data : '0;
endmodule
